// File: rtl/ram_port_arbiter_pkg.sv
// Memory-bus sizes shared by the cache controllers and the RAM port arbiter.
// Block-granular addressing: a 32-bit byte address minus the block-offset bits.
package ram_port_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W     = 32;
  localparam int unsigned BLOCK_ADDR_LSB = 4;
  localparam int unsigned MEM_BADDR_W    = MEM_ADDR_W - BLOCK_ADDR_LSB;
  localparam int unsigned MEM_BLOCK_W    = 8 << BLOCK_ADDR_LSB;

  // One registered block request as presented to the RAM port.
  typedef struct packed {
    logic                   en;
    logic                   we;
    logic [MEM_BADDR_W-1:0] baddr;
    logic [MEM_BLOCK_W-1:0] din;
  } blk_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StGrantI,
    StGrantD
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin picker.
// Ports:
//   clk_i, rst_ni - clock, async active-low reset
//   req_i[1:0]    - requests (bit 0 = icache, bit 1 = dcache)
//   take_i        - the grant is consumed this cycle (updates last-grant)
//   gnt_o[1:0]    - one-hot grant, combinational from req_i and last-grant
module ram_port_arbiter_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic [1:0] gnt_o
);

  // Index of the port granted most recently; resets to dcache so icache wins the first tie.
  logic last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (take_i && (req_i != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single block-wide RAM port between the icache (refills) and the
// dcache (refills and writebacks). Requests are captured in IDLE, one transfer
// runs at a time, and completion is routed back to the owner.
// Ports:
//   clk, RESET                       - clock, async active-low reset
//   i_en/i_baddr/i_dout/i_hold       - icache block read channel
//   d_en/d_we/d_baddr/d_din/d_dout/d_hold - dcache block channel
//   ram_en/ram_we/ram_baddr/ram_din  - registered RAM request
//   ram_dout/ram_hold                - RAM read data and busy
//   timeout_err                      - sticky, a transfer waited TIMEOUT cycles
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned BADDR_W = MEM_BADDR_W,
  parameter int unsigned BLOCK_W = MEM_BLOCK_W,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               i_en,
  input  logic [BADDR_W-1:0] i_baddr,
  output logic [BLOCK_W-1:0] i_dout,
  output logic               i_hold,
  input  logic               d_en,
  input  logic               d_we,
  input  logic [BADDR_W-1:0] d_baddr,
  input  logic [BLOCK_W-1:0] d_din,
  output logic [BLOCK_W-1:0] d_dout,
  output logic               d_hold,
  output logic               ram_en,
  output logic               ram_we,
  output logic [BADDR_W-1:0] ram_baddr,
  output logic [BLOCK_W-1:0] ram_din,
  input  logic [BLOCK_W-1:0] ram_dout,
  input  logic               ram_hold,
  output logic               timeout_err
);

  arb_state_t         state_q;
  blk_req_t           req_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               timeout_q;
  logic [BLOCK_W-1:0] i_dout_q;
  logic [BLOCK_W-1:0] d_dout_q;
  logic [1:0]         gnt;
  logic               i_done;
  logic               d_done;
  logic               i_upd;
  logic               d_upd;

  ram_port_arbiter_rr_arb2 u_rr_arb2 (
    .clk_i  (clk),
    .rst_ni (RESET),
    .req_i  ({d_en, i_en}),
    .take_i (state_q == StIdle),
    .gnt_o  (gnt)
  );

  assign i_done = (state_q == StGrantI) && !ram_hold;
  assign d_done = (state_q == StGrantD) && !ram_hold;
  // A requester that dropped en mid-grant gets nothing; writebacks return no line.
  assign i_upd  = i_done && i_en;
  assign d_upd  = d_done && d_en && !req_q.we;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      req_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      i_dout_q  <= '0;
      d_dout_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (gnt[0]) begin
            state_q <= StGrantI;
            req_q   <= '{en: 1'b1, we: 1'b0, baddr: i_baddr, din: '0};
          end else if (gnt[1]) begin
            state_q <= StGrantD;
            req_q   <= '{en: 1'b1, we: d_we, baddr: d_baddr, din: d_din};
          end
        end
        StGrantI, StGrantD: begin
          if (!ram_hold) begin
            state_q  <= StIdle;
            req_q.en <= 1'b0;
            if (i_upd) i_dout_q <= ram_dout;
            if (d_upd) d_dout_q <= ram_dout;
          end else if (cnt_q != CNT_W'(TIMEOUT)) begin
            // Saturates at TIMEOUT; the grant keeps waiting on the RAM.
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ram_en      = req_q.en;
  assign ram_we      = req_q.we;
  assign ram_baddr   = req_q.baddr;
  assign ram_din     = req_q.din;
  assign timeout_err = timeout_q;

  // Completion cycle forwards the RAM line; the register holds it afterwards.
  assign i_dout = i_upd ? ram_dout : i_dout_q;
  assign d_dout = d_upd ? ram_dout : d_dout_q;

  assign i_hold = i_en && !i_done;
  assign d_hold = d_en && !d_done;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic         clk = 1'b0;
  logic         RESET;
  logic         i_en, d_en, d_we;
  logic [27:0]  i_baddr, d_baddr, ram_baddr;
  logic [127:0] i_dout, d_dout, d_din, ram_din, ram_dout;
  logic         i_hold, d_hold, ram_en, ram_we, ram_hold, timeout_err;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;

  // Behavioural RAM: busy for ram_lat cycles of each request, or forever when stuck.
  int unsigned  ram_lat = 0;
  logic         ram_stuck = 1'b0;
  int unsigned  wait_cnt = 0;
  logic [127:0] ram_line = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_en || !ram_hold) wait_cnt <= 0;
    else                      wait_cnt <= wait_cnt + 1;
  end
  assign ram_hold = ram_en && (ram_stuck || (wait_cnt < ram_lat));
  assign ram_dout = ram_line;

  ram_port_arbiter #(
    .TIMEOUT (8),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .RESET       (RESET),
    .i_en        (i_en),
    .i_baddr     (i_baddr),
    .i_dout      (i_dout),
    .i_hold      (i_hold),
    .d_en        (d_en),
    .d_we        (d_we),
    .d_baddr     (d_baddr),
    .d_din       (d_din),
    .d_dout      (d_dout),
    .d_hold      (d_hold),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_baddr   (ram_baddr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .ram_hold    (ram_hold),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic         is_d;
    logic         we;
    logic [27:0]  baddr;
    logic [127:0] din;
    int unsigned  lat;
    logic [127:0] line;
    logic         exp_ram_we;
    logic [127:0] exp_ram_din;
    logic [127:0] exp_i_dout;
    logic [127:0] exp_d_dout;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET     = 1'b0;
    ram_stuck = 1'b0;
    ram_lat   = 0;
    i_en = 1'b0; d_en = 1'b0; d_we = 1'b0;
    i_baddr = '0; d_baddr = '0; d_din = '0;
    repeat (2) tick();
    RESET = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got;
    int unsigned dcnt;
    int unsigned cyc;

    vecs[0] = '{1'b0, 1'b0, 28'h0000123, '0, 3,
                128'h01234567_89abcdef_fedcba98_76543210, 1'b0, '0,
                128'h01234567_89abcdef_fedcba98_76543210, '0};
    vecs[1] = '{1'b1, 1'b0, 28'h0FFFFFF, '0, 0,
                128'hdeadbeef_00000000_00000000_00000001, 1'b0, '0,
                128'h01234567_89abcdef_fedcba98_76543210,
                128'hdeadbeef_00000000_00000000_00000001};
    vecs[2] = '{1'b1, 1'b1, 28'h00000AB, 128'hcafef00d_11112222_33334444_55556666, 1,
                128'h55555555_55555555_55555555_55555555, 1'b1,
                128'hcafef00d_11112222_33334444_55556666,
                128'h01234567_89abcdef_fedcba98_76543210,
                128'hdeadbeef_00000000_00000000_00000001};
    vecs[3] = '{1'b0, 1'b0, 28'hFFFFFFF, '0, 0,
                128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_a5a5a5a5, 1'b0, '0,
                128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_a5a5a5a5,
                128'hdeadbeef_00000000_00000000_00000001};
    vecs[4] = '{1'b1, 1'b0, 28'h8000001, '0, 2,
                128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f, 1'b0, '0,
                128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_a5a5a5a5,
                128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f};

    do_reset();
    #1;
    check("rst ram_en", ram_en, 0);
    check("rst ram_we", ram_we, 0);
    check("rst ram_baddr", ram_baddr, 0);
    check("rst ram_din", ram_din, 0);
    check("rst i_dout", i_dout, 0);
    check("rst d_dout", d_dout, 0);
    check("rst timeout_err", timeout_err, 0);
    check("rst holds", {i_hold, d_hold}, 0);

    // Single transfers, one requester at a time.
    for (int v = 0; v < 5; v++) begin
      tick();
      ram_lat  = vecs[v].lat;
      ram_line = vecs[v].line;
      if (vecs[v].is_d) begin
        d_en = 1'b1; d_we = vecs[v].we; d_baddr = vecs[v].baddr; d_din = vecs[v].din;
        i_baddr = 28'h5A5A5A5;
      end else begin
        i_en = 1'b1; i_baddr = vecs[v].baddr;
        d_we = 1'b1; d_din = 128'hffff0000_ffff0000_ffff0000_ffff0000;
      end
      #1;
      check($sformatf("v%0d idle ram_en", v), ram_en, 0);
      check($sformatf("v%0d req hold", v), vecs[v].is_d ? d_hold : i_hold, 1);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 50) begin
        tick();
        #1;
        cyc++;
        if (cyc == 1) begin
          check($sformatf("v%0d ram_en", v), ram_en, 1);
          check($sformatf("v%0d ram_baddr", v), ram_baddr, vecs[v].baddr);
          check($sformatf("v%0d ram_we", v), ram_we, vecs[v].exp_ram_we);
          check($sformatf("v%0d ram_din", v), ram_din, vecs[v].exp_ram_din);
        end
        check($sformatf("v%0d other hold", v), vecs[v].is_d ? i_hold : d_hold, 0);
        if (!(vecs[v].is_d ? d_hold : i_hold)) got = 1'b1;
      end
      check($sformatf("v%0d latency", v), cyc, vecs[v].lat + 1);
      check($sformatf("v%0d i_dout", v), i_dout, vecs[v].exp_i_dout);
      check($sformatf("v%0d d_dout", v), d_dout, vecs[v].exp_d_dout);
      tick();
      i_en = 1'b0; d_en = 1'b0;
      #1;
      check($sformatf("v%0d bubble ram_en", v), ram_en, 0);
      check($sformatf("v%0d held i_dout", v), i_dout, vecs[v].exp_i_dout);
      check($sformatf("v%0d held d_dout", v), d_dout, vecs[v].exp_d_dout);
    end

    // Simultaneous requests: icache first after reset, then dcache on the next tie.
    do_reset();
    tick();
    ram_lat = 0;
    i_en = 1'b1; i_baddr = 28'h0000042;
    d_en = 1'b1; d_we = 1'b1; d_baddr = 28'h00000AB;
    d_din = 128'h11223344_55667788_99aabbcc_ddeeff00;
    #1;
    check("tie0 holds", {i_hold, d_hold}, 2'b11);
    tick(); #1;
    check("tie1 ram_baddr", ram_baddr, 28'h0000042);
    check("tie1 ram_we", ram_we, 0);
    check("tie1 holds", {i_hold, d_hold}, 2'b01);
    i_baddr = 28'h0000043;
    tick(); #1;
    check("tie2 bubble", ram_en, 0);
    check("tie2 holds", {i_hold, d_hold}, 2'b11);
    tick(); #1;
    check("tie3 ram_baddr", ram_baddr, 28'h00000AB);
    check("tie3 ram_we", ram_we, 1);
    check("tie3 ram_din", ram_din, 128'h11223344_55667788_99aabbcc_ddeeff00);
    check("tie3 holds", {i_hold, d_hold}, 2'b10);
    d_en = 1'b0;
    tick(); tick(); #1;
    check("tie5 ram_baddr", ram_baddr, 28'h0000043);
    check("tie5 i_hold", i_hold, 0);
    i_en = 1'b0;

    // Fairness: dcache never lets go, icache pulses.
    tick();
    d_en = 1'b1; d_we = 1'b0; ram_lat = 2;
    for (int p = 0; p < 3; p++) begin
      repeat (3 + p) tick();
      i_en = 1'b1; i_baddr = 28'(p);
      got = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        tick(); #1;
        if (!d_hold) dcnt++;
        if (!i_hold) got = 1'b1;
      end
      check($sformatf("fair%0d done", p), got, 1);
      check($sformatf("fair%0d d transfers", p), dcnt <= 1, 1);
      tick();
      i_en = 1'b0;
    end
    d_en = 1'b0;
    repeat (6) tick();

    // Timeout with a stuck RAM.
    do_reset();
    ram_stuck = 1'b1;
    tick();
    d_en = 1'b1; d_we = 1'b0; d_baddr = 28'h0000005;
    for (int g = 1; g <= 12; g++) begin
      tick(); #1;
      check($sformatf("to g%0d ram_en", g), ram_en, 1);
      check($sformatf("to g%0d err", g), timeout_err, g > 8);
    end
    ram_line  = 128'h1;
    ram_stuck = 1'b0;
    #1;
    check("to release d_hold", d_hold, 0);
    tick();
    d_en = 1'b0;
    #1;
    check("to sticky", timeout_err, 1);
    RESET = 1'b0;
    #1;
    check("to cleared", timeout_err, 0);
    RESET = 1'b1;

    // Reset during GRANT_D.
    tick();
    ram_lat  = 0;
    ram_line = 128'h77777777_00000000_00000000_00000001;
    d_en = 1'b1; d_we = 1'b0; d_baddr = 28'h0000010;
    tick(); #1;
    check("mid refill d_dout", d_dout, 128'h77777777_00000000_00000000_00000001);
    tick();
    d_en = 1'b0;
    tick();
    ram_stuck = 1'b1;
    d_en = 1'b1;
    tick(); #1;
    check("mid grant ram_en", ram_en, 1);
    tick(); #1;
    RESET = 1'b0;
    #1;
    check("mid async ram_en", ram_en, 0);
    check("mid d_dout", d_dout, 0);
    check("mid d_hold", d_hold, 1);
    RESET = 1'b1;
    #1;
    check("mid post ram_en", ram_en, 0);
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      check($sformatf("mid no spurious %0d", c), d_hold, 1);
    end
    check("mid final d_dout", d_dout, 0);
    d_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single block-wide (128-bit) backing-RAM port between the instruction cache (read-only refills) and the data cache (refills and dirty-line writebacks).
- Sits between both cache controllers and the RAM: requests are registered, one block transfer is granted at a time, and completion is routed back to the owner.
- Round-robin when both caches request in the same cycle. A sticky timeout flag catches a stalled RAM.

Parameters:
- BADDR_W, 28, block address width (32-bit byte address minus 4 block-offset bits).
- BLOCK_W, 128, cache line width in bits.
- TIMEOUT, 1024, cycles a granted transfer may wait for RAM completion before timeout_err is set.
- CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_en  in  1  icache block read request; held until i_hold is seen low.
- i_baddr  in  BADDR_W  icache block address.
- i_dout  out  BLOCK_W  refill line returned to icache.
- i_hold  out  1  icache must stall; low with i_en high marks completion.
- d_en  in  1  dcache block request.
- d_we  in  1  dcache: 1 = writeback, 0 = refill.
- d_baddr  in  BADDR_W  dcache block address.
- d_din  in  BLOCK_W  writeback line.
- d_dout  out  BLOCK_W  refill line returned to dcache.
- d_hold  out  1  dcache stall; low with d_en high marks completion.
- ram_en  out  1  RAM request valid.
- ram_we  out  1  RAM write.
- ram_baddr  out  BADDR_W  RAM block address.
- ram_din  out  BLOCK_W  RAM write data.
- ram_dout  in  BLOCK_W  RAM read data, valid in the cycle ram_hold is low.
- ram_hold  in  1  RAM busy; low while ram_en is high means the transfer completes this cycle.
- timeout_err  out  1  sticky, set when a transfer exceeds TIMEOUT cycles.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D. FSM state, request registers, last_grant, counter and timeout_err are all asynchronously cleared when RESET = 0.
- Reset values:
  - state = IDLE; ram_en = 0, ram_we = 0, ram_baddr = 0, ram_din = 0.
  - i_dout = 0, d_dout = 0; timeout_err = 0; last_grant = D, so icache wins the first tie.
- IDLE:
  - Only i_en → capture i_baddr and go to GRANT_I.
  - Only d_en → capture d_we/d_baddr/d_din and go to GRANT_D.
  - Both → grant the requester that was not last_grant, then update last_grant.
  - Neither → stay in IDLE.
- GRANT_x:
  - ram_en = 1; ram_we/baddr/din are driven from the registered request, never combinationally from the requester.
  - For icache, ram_we = 0 and ram_din = 0.
- Completion:
  - The first GRANT_x cycle with ram_hold = 0 completes the transfer.
  - That cycle: x_dout = ram_dout (registered, held until the next completion to x), x_hold = 0, next state = IDLE.
  - For a dcache writeback, d_dout is not updated.
- Hold rules:
  - x_hold = x_en AND NOT (state == GRANT_x AND ram_hold == 0).
  - A requester that is not requesting sees hold = 0.
  - A waiting or losing requester sees hold = 1.
- Latency: the request is seen in IDLE at cycle N, ram_en rises at N+1, and the earliest completion is N+1. One IDLE bubble follows each completion, so back-to-back grants are ≥ 2 cycles apart.
- Fairness: a requester that stays asserted is granted within one other transfer.
- Protocol faults:
  - A requester dropping en while granted: the transfer still runs to completion; the result is discarded and hold goes low.
  - Requester inputs changing mid-grant are ignored, because they are registered.
- Timeout:
  - The counter clears on entry to GRANT_x and increments each GRANT_x cycle with ram_hold = 1.
  - When the counter reaches TIMEOUT, timeout_err is set. It stays set until reset, and the grant continues.
- Reset mid-transfer: ram_en drops immediately (async), the FSM returns to IDLE, and no completion is signalled.

Decomposition:
- Shared package (extend the existing memory-bus sizes package):
  - BLOCK_ADDR_LSB-derived BADDR_W and BLOCK_W constants.
  - Typedef blk_req_t {en, we, baddr, din}.
  - Enum arb_state_t {IDLE, GRANT_I, GRANT_D}.
- One natural sub-module: rr_arb2, a 2-input round-robin picker with a last_grant register.
- Interface wrappers binding the existing cache-to-RAM interfaces are kept outside this block.

Test Plan:
1. Reset then icache alone: i_en = 1, i_baddr = 0x0000123, RAM holds 3 cycles. Required: ram_en at cycle 1, ram_baddr = 0x0000123, ram_we = 0; i_hold low on cycle 4 with i_dout = RAM line; FSM back in IDLE at cycle 5.
2. Simultaneous requests: i_en and d_en both rise together, d_we = 1, d_baddr = 0x00000AB, zero-latency RAM. Required: icache granted first (last_grant reset = D), dcache second with ram_we = 1 and ram_din = d_din. A second simultaneous pair is granted to dcache first.
3. Dcache refill: d_we = 0, d_baddr = 0x0FFFFFF, RAM returns 0xDEADBEEF_…_0001. Required: d_dout matches exactly; i_hold = 0 throughout with i_en low.
4. Starvation: d_en held high continuously while i_en pulses. Required: every icache request completes after at most one dcache transfer.
5. Timeout: ram_hold stuck high with TIMEOUT = 8. Required: timeout_err rises after exactly 8 GRANT cycles, stays set, and clears only on RESET = 0.
6. Reset mid-transfer: assert RESET low in GRANT_D. Required: ram_en = 0 in the same cycle (async); after release, state = IDLE, d_dout = 0, no spurious hold-low completion.
